// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between the CPU
//   instruction-fetch port and the data load/store port. One transaction is
//   in flight at a time. Its address, write data and size are latched at
//   grant. Completion comes back as a one-cycle ack with registered read data.
//   When both ports request at once, the port that did not win last time is
//   granted.
//
// Ports
//   CLK, Reset          clock, synchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ack) and address
//   i_ack/i_rdata       fetch completion pulse and fetched word
//   i_stall             fetch port waiting (i_req & ~i_ack)
//   d_rd_en/d_wr_en     load / store request (held until d_ack)
//   d_addr/d_wdata      data address, store data
//   d_type              transfer size/sign code
//   d_ack/d_rdata       data completion pulse and load data (0 for stores)
//   d_stall             data port waiting
//   err                 pulses with the ack of a timed-out transaction
//   timeout_flag        sticky timeout indicator, cleared only by Reset
//   mem_req/mem_we      memory request (held through BUSY), write enable
//   mem_addr/mem_wdata  latched address and write data
//   mem_type            latched size code (word for fetches)
//   mem_ack/mem_rdata   memory completion and read data

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_rd_en,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_type,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              err,
  output logic              timeout_flag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_type,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The counter only has to reach TIMEOUT-1. When TIMEOUT is 0 it may wrap
  // freely because the timeout compare is disabled.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] TYPE_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic                last_d_reg, last_d_next;   // 1 = last grant went to data
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [2:0]          type_reg, type_next;
  logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
  logic                err_reg, err_next;
  logic                tflag_reg, tflag_next;

  logic d_req;
  logic grant_d;
  logic timed_out;

  assign d_req     = d_rd_en | d_wr_en;
  assign timed_out = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg   <= IDLE;
      last_d_reg  <= 1'b0;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      type_reg    <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
      err_reg     <= 1'b0;
      tflag_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_d_reg  <= last_d_next;
      cnt_reg     <= cnt_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      type_reg    <= type_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
      err_reg     <= err_next;
      tflag_reg   <= tflag_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_d_next  = last_d_reg;
    cnt_next     = '0;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    type_next    = type_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    err_next     = 1'b0;
    tflag_next   = tflag_reg;
    grant_d      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          // Data wins a tie unless it also won the previous grant.
          grant_d = d_req && !(i_req && last_d_reg);
          if (grant_d) begin
            state_next  = BUSY_D;
            last_d_next = 1'b1;
            we_next     = d_wr_en;  // rd and wr both high is a store
            addr_next   = d_addr;
            wdata_next  = d_wdata;
            type_next   = d_type;
          end else begin
            state_next  = BUSY_I;
            last_d_next = 1'b0;
            we_next     = 1'b0;
            addr_next   = i_addr;
            wdata_next  = '0;
            type_next   = TYPE_WORD;
          end
        end
      end

      BUSY_I: begin
        cnt_next = cnt_reg + 1'b1;
        if (mem_ack) begin
          i_rdata_next = mem_rdata;
          state_next   = RESP_I;
        end else if (timed_out) begin
          i_rdata_next = '0;
          err_next     = 1'b1;
          tflag_next   = 1'b1;
          state_next   = RESP_I;
        end
      end

      BUSY_D: begin
        cnt_next = cnt_reg + 1'b1;
        if (mem_ack) begin
          d_rdata_next = we_reg ? '0 : mem_rdata;
          state_next   = RESP_D;
        end else if (timed_out) begin
          d_rdata_next = '0;
          err_next     = 1'b1;
          tflag_next   = 1'b1;
          state_next   = RESP_D;
        end
      end

      // Requests still high here are not sampled, so each request yields one ack.
      RESP_I, RESP_D: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign mem_req      = (state_reg == BUSY_I) || (state_reg == BUSY_D);
  assign mem_we       = we_reg;
  assign mem_addr     = addr_reg;
  assign mem_wdata    = wdata_reg;
  assign mem_type     = type_reg;
  assign i_ack        = (state_reg == RESP_I);
  assign d_ack        = (state_reg == RESP_D);
  assign i_rdata      = i_rdata_reg;
  assign d_rdata      = d_rdata_reg;
  assign err          = err_reg;
  assign timeout_flag = tflag_reg;
  assign i_stall      = i_req & ~i_ack;
  assign d_stall      = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (TIMEOUT=8). A transaction-level
//   reference model predicts every output on every cycle. Directed tests pin
//   the model with hand-computed values: fetch latency, contention order,
//   store-field latching, timeout, reset while busy, and a withdrawn request.
//   The memory responder acks a configurable number of cycles into a
//   request, or never acks.

module tb_mem_port_arbiter;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_rd_en = 1'b0;
  logic        d_wr_en = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_type = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        err;
  logic        timeout_flag;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_type;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Memory responder controls
  logic ack_en = 1'b0;
  int   ack_delay = 0;
  logic stray_ack = 1'b0;
  int   req_age = 0;
  int   cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_type(d_type), .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .err(err), .timeout_flag(timeout_flag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    req_age <= mem_req ? req_age + 1 : 0;
  end

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0050_0093 : {~a[15:0], a[15:0]};
  endfunction

  // mem_rdata carries junk when not acking, so data captured without an ack shows up.
  assign mem_ack   = stray_ack | (mem_req & ack_en & (req_age == ack_delay));
  assign mem_rdata = mem_ack ? data_for(mem_addr) : 32'hBAD0_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (one transaction record) ----------------
  typedef enum {PH_IDLE, PH_MEM, PH_RESP} phase_t;
  phase_t      m_phase = PH_IDLE;
  bit          m_on_d = 1'b0;   // current transaction belongs to the data port
  bit          m_last_d = 1'b0; // previous grant went to the data port
  int          m_age = 0;       // cycles spent with mem_req high
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_irdata = '0, m_drdata = '0;
  logic [2:0]  m_type = '0;
  logic        m_err = 1'b0, m_tflag = 1'b0;
  bit          model_valid = 1'b0;

  task automatic model_step();
    bit dreq;
    dreq = d_rd_en | d_wr_en;
    if (Reset) begin
      m_phase = PH_IDLE; m_last_d = 0; m_age = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_type = '0; m_irdata = '0; m_drdata = '0;
      m_err = 0; m_tflag = 0;
    end else begin
      m_err = 0;
      case (m_phase)
        PH_RESP: m_phase = PH_IDLE;
        PH_MEM: begin
          m_age++;
          if (mem_ack) begin
            if (m_on_d) m_drdata = m_we ? 32'h0 : mem_rdata;
            else        m_irdata = mem_rdata;
            m_phase = PH_RESP;
          end else if (TMO != 0 && m_age == TMO) begin
            if (m_on_d) m_drdata = '0; else m_irdata = '0;
            m_err = 1; m_tflag = 1; m_phase = PH_RESP;
          end
        end
        default: begin
          if (i_req || dreq) begin
            m_on_d = dreq && !(i_req && m_last_d);
            m_last_d = m_on_d;
            m_age = 0;
            m_phase = PH_MEM;
            if (m_on_d) begin
              m_we = d_wr_en; m_addr = d_addr; m_wdata = d_wdata; m_type = d_type;
            end else begin
              m_we = 0; m_addr = i_addr; m_wdata = '0; m_type = 3'b010;
            end
          end
        end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      model_step();
      model_valid = 1'b1;
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge CLK);
      if (model_valid) begin
        check("mem_req",      mem_req,      m_phase == PH_MEM);
        check("mem_we",       mem_we,       m_we);
        check("mem_addr",     mem_addr,     m_addr);
        check("mem_wdata",    mem_wdata,    m_wdata);
        check("mem_type",     mem_type,     m_type);
        check("i_ack",        i_ack,        m_phase == PH_RESP && !m_on_d);
        check("d_ack",        d_ack,        m_phase == PH_RESP && m_on_d);
        check("i_rdata",      i_rdata,      m_irdata);
        check("d_rdata",      d_rdata,      m_drdata);
        check("err",          err,          m_err);
        check("timeout_flag", timeout_flag, m_tflag);
        check("i_stall",      i_stall,      i_req & !(m_phase == PH_RESP && !m_on_d));
        check("d_stall",      d_stall,      (d_rd_en | d_wr_en) & !(m_phase == PH_RESP && m_on_d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for an ack on one port; returns at the negedge of the ack cycle.
  task automatic wait_ack(input bit on_d, input int budget, output bit got, output int nreq);
    got = 0;
    nreq = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (on_d ? d_ack : i_ack) begin
        got = 1;
        break;
      end
      if (mem_req) nreq++;
      tick();
    end
  endtask

  initial begin
    bit got;
    int nreq;
    int r_cyc;
    int ports[$];
    int cycs[$];
    int exp_ports[4];
    int cnt;

    exp_ports[0] = 1; exp_ports[1] = 0; exp_ports[2] = 1; exp_ports[3] = 0;

    // Reset state
    tick(); tick();
    @(negedge CLK);
    check("rst_mem_req", mem_req, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    tick();
    Reset = 0;

    // 1: single fetch, memory acks in the first BUSY cycle
    tick();
    ack_en = 1; ack_delay = 0;
    i_req = 1; i_addr = 32'h40;
    @(negedge CLK);
    check("t1_stall_idle", i_stall, 1);
    tick();
    @(negedge CLK);
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h40);
    check("t1_mem_type", mem_type, 3'b010);
    check("t1_mem_we", mem_we, 0);
    check("t1_no_early_ack", i_ack, 0);
    check("t1_stall_busy", i_stall, 1);
    tick();
    @(negedge CLK);
    check("t1_i_ack", i_ack, 1);
    check("t1_i_rdata", i_rdata, 32'h0050_0093);
    check("t1_stall_resp", i_stall, 0);
    tick();
    i_req = 0;
    tick(); tick();

    // 2: contention from reset, immediate acks -> D, I, D, I, 3 cycles apart
    Reset = 1;
    i_req = 1; i_addr = 32'h44;
    d_rd_en = 1; d_addr = 32'h300;
    tick(); tick();
    Reset = 0;
    r_cyc = cyc;
    for (int k = 0; k < 20 && ports.size() < 4; k++) begin
      @(negedge CLK);
      if (d_ack) begin ports.push_back(1); cycs.push_back(cyc); end
      if (i_ack) begin ports.push_back(0); cycs.push_back(cyc); end
      tick();
    end
    i_req = 0; d_rd_en = 0;
    check("t2_ack_count", ports.size(), 4);
    for (int k = 0; k < ports.size() && k < 4; k++) begin
      check("t2_grant_order", ports[k], exp_ports[k]);
      if (k == 0) check("t2_first_latency", cycs[0] - r_cyc, 2);
      else        check("t2_ack_spacing", cycs[k] - cycs[k-1], 3);
    end
    tick(); tick();

    // 3: store; requester changes d_wdata during BUSY, mem_wdata must hold
    ack_delay = 2;
    d_wr_en = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_type = 3'b000;
    tick();
    @(negedge CLK);
    check("t3_mem_req", mem_req, 1);
    check("t3_mem_we", mem_we, 1);
    check("t3_mem_addr", mem_addr, 32'h100);
    check("t3_mem_type", mem_type, 3'b000);
    check("t3_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
    tick();
    d_wdata = 32'h0;
    @(negedge CLK);
    check("t3_wdata_c2", mem_wdata, 32'hDEAD_BEEF);
    tick();
    @(negedge CLK);
    check("t3_wdata_c3", mem_wdata, 32'hDEAD_BEEF);
    check("t3_req_c3", mem_req, 1);
    tick();
    @(negedge CLK);
    check("t3_d_ack", d_ack, 1);
    check("t3_d_rdata", d_rdata, 0);
    tick();
    d_wr_en = 0;
    tick();

    // 4: timeout, memory never acks
    ack_en = 0;
    d_rd_en = 1; d_addr = 32'h200; d_type = 3'b010;
    wait_ack(1'b1, 30, got, nreq);
    check("t4_ack_seen", got, 1);
    check("t4_req_cycles", nreq, TMO);
    check("t4_err", err, 1);
    check("t4_d_rdata", d_rdata, 0);
    check("t4_flag", timeout_flag, 1);
    tick();
    d_rd_en = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("t4_flag_sticky", timeout_flag, 1);
      check("t4_err_pulse", err, 0);
      tick();
    end

    // 5: reset in the second BUSY cycle of a fetch
    i_req = 1; i_addr = 32'h80;
    tick();
    @(negedge CLK);
    check("t5_busy1", mem_req, 1);
    tick();
    Reset = 1; i_req = 0;
    @(negedge CLK);
    check("t5_busy2", mem_req, 1);
    tick();
    Reset = 0;
    @(negedge CLK);
    check("t5_mem_req", mem_req, 0);
    check("t5_flag", timeout_flag, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_i_rdata", i_rdata, 0);
    check("t5_d_rdata", d_rdata, 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge CLK);
      if (i_ack) cnt++;
    end
    check("t5_no_ack", cnt, 0);
    tick();
    ack_en = 1; ack_delay = 1;
    i_req = 1; i_addr = 32'h40;
    wait_ack(1'b0, 10, got, nreq);
    check("t5_fresh_ack", got, 1);
    check("t5_fresh_busy", nreq, 2);
    check("t5_fresh_rdata", i_rdata, 32'h0050_0093);
    tick();
    i_req = 0;
    tick();

    // 6: fetch withdrawn one cycle into BUSY; stray mem_ack afterwards
    ack_delay = 3;
    i_req = 1; i_addr = 32'h48;
    tick();
    tick();
    i_req = 0;
    wait_ack(1'b0, 12, got, nreq);
    check("t6_ack_seen", got, 1);
    check("t6_busy_rest", nreq, 3);
    check("t6_i_rdata", i_rdata, {~16'h0048, 16'h0048});
    tick();
    stray_ack = 1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (i_ack || d_ack || mem_req) cnt++;
      tick();
    end
    stray_ack = 0;
    check("t6_quiet_after", cnt, 0);

    // 7: load then rd+wr together (treated as a store)
    ack_delay = 0;
    d_rd_en = 1; d_addr = 32'h108;
    wait_ack(1'b1, 10, got, nreq);
    check("t7_load_ack", got, 1);
    check("t7_load_rdata", d_rdata, {~16'h0108, 16'h0108});
    tick();
    d_rd_en = 0;
    tick();
    d_rd_en = 1; d_wr_en = 1; d_addr = 32'h104; d_wdata = 32'h1234_5678; d_type = 3'b001;
    tick();
    @(negedge CLK);
    check("t7_both_we", mem_we, 1);
    check("t7_both_wdata", mem_wdata, 32'h1234_5678);
    tick();
    @(negedge CLK);
    check("t7_both_ack", d_ack, 1);
    check("t7_both_rdata", d_rdata, 0);
    tick();
    d_rd_en = 0; d_wr_en = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
